// File: rtl/tiny45_mem_defs_pkg.sv
// Shared definitions for the tiny45 memory arbiter: size codes, FSM states,
// funct3 load/store codes and the load-extension helper.
package tiny45_mem_defs_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;
    localparam logic [1:0] MEM_IDLE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_STORE,
        ST_STREAM
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // funct3[2] selects zero extension (LBU/LHU); otherwise sign-extend.
    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [2:0] op);
        logic sgn;
        sgn = 1'b0;
        extend_load = word;
        case (op[1:0])
            MEM_BYTE: begin
                sgn = ~op[2] & word[7];
                extend_load = {{24{sgn}}, word[7:0]};
            end
            MEM_HALF: begin
                sgn = ~op[2] & word[15];
                extend_load = {{16{sgn}}, word[15:0]};
            end
            default: extend_load = word;
        endcase
    endfunction

endpackage

// File: rtl/tiny45_instr_fifo.sv
// Two-entry 16-bit instruction halfword buffer; flush overrides push and pop.
module tiny45_instr_fifo
    import tiny45_mem_defs_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        push,
    input  logic [15:0] push_data,
    input  logic        pop,
    input  logic        flush,
    output logic [15:0] head,
    output logic        valid,
    output logic        full
);

    logic [15:0] mem_reg [2];
    logic        rd_ptr_reg;
    logic        wr_ptr_reg;
    logic [1:0]  count_reg;
    logic        do_push;
    logic        do_pop;

    assign valid   = (count_reg != 2'd0);
    assign full    = (count_reg == 2'(DEPTH));
    assign head    = mem_reg[rd_ptr_reg];
    assign do_push = push && !full;
    assign do_pop  = pop && valid;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 2; i++) begin
                mem_reg[i] <= '0;
            end
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else if (flush) begin
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (do_pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 2'd1;
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - 2'd1;
            end
        end
    end

endmodule

// File: rtl/tiny45_mem_arbiter.sv
// Shares one external memory port between instruction prefetch and the core's
// load/store path; load data is returned nibble-serially on the core's counter.
module tiny45_mem_arbiter
    import tiny45_mem_defs_pkg::*;
#(
    parameter int ADDR_BITS  = 24,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [2:0]             counter,
    input  logic [ADDR_BITS-1:1]   instr_addr,
    input  logic                   instr_restart,
    input  logic                   instr_pop,
    output logic [15:0]            instr_data,
    output logic                   instr_valid,
    input  logic [ADDR_BITS-1:0]   data_addr,
    input  logic [2:0]             data_op,
    input  logic                   data_load,
    input  logic                   data_store,
    input  logic [31:0]            data_wdata,
    output logic                   data_busy,
    output logic [3:0]             load_nibble,
    output logic                   load_data_ready,
    output logic [ADDR_BITS-1:0]   mem_addr,
    output logic [1:0]             mem_read_n,
    output logic [1:0]             mem_write_n,
    output logic [31:0]            mem_wdata,
    input  logic                   mem_busy,
    input  logic [31:0]            mem_rdata,
    input  logic                   mem_rdata_ready
);

    state_t                 state_reg;
    logic                   accepted_reg;
    logic                   discard_reg;
    logic                   streaming_reg;
    logic [ADDR_BITS-1:1]   fetch_ptr_reg;
    logic                   pend_reg;
    logic                   pend_load_reg;
    logic [ADDR_BITS-1:0]   pend_addr_reg;
    logic [2:0]             pend_op_reg;
    logic [31:0]            pend_wdata_reg;
    logic                   busy_reg;
    logic [31:0]            word_reg;
    logic [ADDR_BITS-1:0]   mem_addr_reg;
    logic [1:0]             mem_read_n_reg;
    logic [1:0]             mem_write_n_reg;
    logic [31:0]            mem_wdata_reg;
    logic [3:0]             load_nibble_reg;
    logic                   ready_reg;

    logic                   buf_full;
    logic                   new_req;
    logic                   accept_now;
    logic                   fetch_done;
    logic                   push;
    logic [2:0]             nib_idx;

    assign new_req    = (data_load || data_store) && !busy_reg;
    assign accept_now = accepted_reg || !mem_busy;
    assign fetch_done = (state_reg == ST_FETCH) && mem_rdata_ready && accept_now;
    // Data from a fetch that was in flight across a restart belongs to the old stream.
    assign push       = fetch_done && !discard_reg && !instr_restart;
    assign nib_idx    = counter + 3'd1;

    tiny45_instr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data (mem_rdata[15:0]),
        .pop       (instr_pop),
        .flush     (instr_restart),
        .head      (instr_data),
        .valid     (instr_valid),
        .full      (buf_full)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg       <= ST_IDLE;
            accepted_reg    <= 1'b0;
            discard_reg     <= 1'b0;
            streaming_reg   <= 1'b0;
            fetch_ptr_reg   <= '0;
            pend_reg        <= 1'b0;
            pend_load_reg   <= 1'b0;
            pend_addr_reg   <= '0;
            pend_op_reg     <= 3'd0;
            pend_wdata_reg  <= 32'd0;
            busy_reg        <= 1'b0;
            word_reg        <= 32'd0;
            mem_addr_reg    <= '0;
            mem_read_n_reg  <= MEM_IDLE;
            mem_write_n_reg <= MEM_IDLE;
            mem_wdata_reg   <= 32'd0;
            load_nibble_reg <= 4'd0;
            ready_reg       <= 1'b0;
        end else begin
            if (instr_restart) begin
                fetch_ptr_reg <= instr_addr;
            end else if (push) begin
                fetch_ptr_reg <= fetch_ptr_reg + {{(ADDR_BITS-2){1'b0}}, 1'b1};
            end

            if (new_req) begin
                pend_reg       <= 1'b1;
                busy_reg       <= 1'b1;
                pend_load_reg  <= data_load;
                pend_addr_reg  <= data_addr;
                pend_op_reg    <= data_op;
                pend_wdata_reg <= data_wdata;
            end

            case (state_reg)
                ST_IDLE: begin
                    accepted_reg <= 1'b0;
                    if (pend_reg) begin
                        pend_reg     <= 1'b0;
                        mem_addr_reg <= pend_addr_reg;
                        if (pend_load_reg) begin
                            mem_read_n_reg <= pend_op_reg[1:0];
                            state_reg      <= ST_LOAD;
                        end else begin
                            mem_write_n_reg <= pend_op_reg[1:0];
                            mem_wdata_reg   <= pend_wdata_reg;
                            state_reg       <= ST_STORE;
                        end
                    end else if (!buf_full && !instr_restart) begin
                        mem_read_n_reg <= MEM_HALF;
                        mem_addr_reg   <= {fetch_ptr_reg, 1'b0};
                        state_reg      <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (!accepted_reg && !mem_busy) begin
                        accepted_reg   <= 1'b1;
                        mem_read_n_reg <= MEM_IDLE;
                    end
                    if (fetch_done) begin
                        discard_reg <= 1'b0;
                        state_reg   <= ST_IDLE;
                    end else if (instr_restart) begin
                        discard_reg <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (!accepted_reg && !mem_busy) begin
                        accepted_reg   <= 1'b1;
                        mem_read_n_reg <= MEM_IDLE;
                    end
                    if (mem_rdata_ready && accept_now) begin
                        word_reg      <= extend_load(mem_rdata, pend_op_reg);
                        streaming_reg <= 1'b0;
                        state_reg     <= ST_STREAM;
                    end
                end
                ST_STORE: begin
                    if (!mem_busy) begin
                        mem_write_n_reg <= MEM_IDLE;
                        busy_reg        <= 1'b0;
                        state_reg       <= ST_IDLE;
                    end
                end
                ST_STREAM: begin
                    // Outputs are registered one cycle ahead so nibble k lines up with counter==k.
                    if (!streaming_reg) begin
                        if (counter == 3'd7) begin
                            streaming_reg   <= 1'b1;
                            ready_reg       <= 1'b1;
                            load_nibble_reg <= word_reg[3:0];
                        end
                    end else if (counter == 3'd7) begin
                        streaming_reg   <= 1'b0;
                        ready_reg       <= 1'b0;
                        load_nibble_reg <= 4'd0;
                        busy_reg        <= 1'b0;
                        state_reg       <= ST_IDLE;
                    end else begin
                        load_nibble_reg <= word_reg[{nib_idx, 2'b00} +: 4];
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign data_busy       = busy_reg;
    assign load_nibble     = load_nibble_reg;
    assign load_data_ready = ready_reg;
    assign mem_addr        = mem_addr_reg;
    assign mem_read_n      = mem_read_n_reg;
    assign mem_write_n     = mem_write_n_reg;
    assign mem_wdata       = mem_wdata_reg;

endmodule

// File: tb/tb_tiny45_mem_arbiter.sv
// Directed bench for tiny45_mem_arbiter with a one-cycle-latency memory responder.
module tb_tiny45_mem_arbiter;
    import tiny45_mem_defs_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [2:0]  counter = 3'd0;
    logic [23:1] instr_addr = '0;
    logic        instr_restart = 1'b0;
    logic        instr_pop = 1'b0;
    logic [15:0] instr_data;
    logic        instr_valid;
    logic [23:0] data_addr = '0;
    logic [2:0]  data_op = 3'd0;
    logic        data_load = 1'b0;
    logic        data_store = 1'b0;
    logic [31:0] data_wdata = 32'd0;
    logic        data_busy;
    logic [3:0]  load_nibble;
    logic        load_data_ready;
    logic [23:0] mem_addr;
    logic [1:0]  mem_read_n;
    logic [1:0]  mem_write_n;
    logic [31:0] mem_wdata;
    logic        mem_busy = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_rdata_ready = 1'b0;

    int          checks = 0;
    int          errors = 0;
    int          rd_count = 0;
    int          base;
    logic [23:0] last_rd_addr = '0;
    logic [1:0]  last_rd_size = 2'b11;
    logic        resp_due = 1'b0;
    logic [31:0] resp_data = 32'd0;
    logic [23:0] load_addr = 24'hFFFFFF;
    logic [31:0] load_word = 32'd0;
    logic        found;

    tiny45_mem_arbiter #(.ADDR_BITS(24), .FIFO_DEPTH(2)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .counter         (counter),
        .instr_addr      (instr_addr),
        .instr_restart   (instr_restart),
        .instr_pop       (instr_pop),
        .instr_data      (instr_data),
        .instr_valid     (instr_valid),
        .data_addr       (data_addr),
        .data_op         (data_op),
        .data_load       (data_load),
        .data_store      (data_store),
        .data_wdata      (data_wdata),
        .data_busy       (data_busy),
        .load_nibble     (load_nibble),
        .load_data_ready (load_data_ready),
        .mem_addr        (mem_addr),
        .mem_read_n      (mem_read_n),
        .mem_write_n     (mem_write_n),
        .mem_wdata       (mem_wdata),
        .mem_busy        (mem_busy),
        .mem_rdata       (mem_rdata),
        .mem_rdata_ready (mem_rdata_ready)
    );

    always #5 clk = ~clk;

    // Free-running core sub-cycle counter.
    always @(posedge clk) counter <= counter + 3'd1;

    // Memory: a read seen on the accept cycle returns one cycle later.
    always @(negedge clk) begin
        mem_rdata_ready = 1'b0;
        if (resp_due) begin
            mem_rdata_ready = 1'b1;
            mem_rdata = resp_data;
            resp_due = 1'b0;
        end
        if (rstn && mem_read_n != 2'b11 && !mem_busy) begin
            rd_count++;
            last_rd_addr = mem_addr;
            last_rd_size = mem_read_n;
            resp_due = 1'b1;
            resp_data = (mem_addr == load_addr) ? load_word : {16'h0, mem_addr[15:0] ^ 16'hC000};
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int limit);
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            if (load_data_ready) found = 1'b1;
            else tick();
        end
    endtask

    task automatic stream_check(input string tag, input logic [31:0] exp_word);
        wait_ready(40);
        check({tag, "_window_seen"}, 32'(found), 32'd1);
        if (found) begin
            check({tag, "_window_counter"}, 32'(counter), 32'd0);
            for (int i = 0; i < 8; i++) begin
                $display("stream %s nibble %0d: got %h exp %h", tag, i, load_nibble, exp_word[4*i +: 4]);
                check({tag, "_nibble"}, 32'(load_nibble), 32'(exp_word[4*i +: 4]));
                check({tag, "_ready_in"}, 32'(load_data_ready), 32'd1);
                tick();
            end
            check({tag, "_ready_after"}, 32'(load_data_ready), 32'd0);
            check({tag, "_busy_after"}, 32'(data_busy), 32'd0);
        end
    endtask

    initial begin
        // Reset values
        tick(3);
        check("rst_read_n", 32'(mem_read_n), 32'h3);
        check("rst_write_n", 32'(mem_write_n), 32'h3);
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_instr_data", 32'(instr_data), 32'h0);
        check("rst_nibble", 32'(load_nibble), 32'h0);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_busy", 32'(data_busy), 32'h0);
        check("rst_ready", 32'(load_data_ready), 32'h0);

        // Prefetch fills the buffer with halfwords at 0 and 2, then stalls
        rstn = 1'b1;
        tick(10);
        $display("prefetch: reads=%0d last=%h valid=%b head=%h", rd_count, last_rd_addr, instr_valid, instr_data);
        check("fill_reads", 32'(rd_count), 32'd2);
        check("fill_last_addr", 32'(last_rd_addr), 32'h2);
        check("fill_valid", 32'(instr_valid), 32'd1);
        check("fill_head", 32'(instr_data), 32'hC000);
        check("fill_stalled", 32'(mem_read_n), 32'h3);

        instr_pop = 1'b1;
        tick();
        instr_pop = 1'b0;
        check("pop_head", 32'(instr_data), 32'hC002);
        tick(6);
        $display("refill: reads=%0d last=%h", rd_count, last_rd_addr);
        check("refill_reads", 32'(rd_count), 32'd3);
        check("refill_addr", 32'(last_rd_addr), 32'h4);

        // LB, sign-extended 0xF0
        load_addr = 24'h001003; load_word = 32'h000000F0;
        data_addr = 24'h001003; data_op = F3_LB; data_load = 1'b1;
        tick();
        data_load = 1'b0;
        check("lb_busy", 32'(data_busy), 32'd1);
        check("lb_ready_before", 32'(load_data_ready), 32'd0);
        stream_check("lb", 32'hFFFFFFF0);
        check("lb_size", 32'(last_rd_size), 32'(MEM_BYTE));
        check("lb_addr", 32'(last_rd_addr), 32'h001003);

        // LHU, zero-extended
        load_addr = 24'h002000; load_word = 32'h1234ABCD;
        data_addr = 24'h002000; data_op = F3_LHU; data_load = 1'b1;
        tick();
        data_load = 1'b0;
        check("lhu_ready_before", 32'(load_data_ready), 32'd0);
        stream_check("lhu", 32'h0000ABCD);
        check("lhu_size", 32'(last_rd_size), 32'(MEM_HALF));

        // SW with mem_busy held for 3 request cycles; a pop makes room for a fetch
        base = rd_count;
        instr_pop = 1'b1; mem_busy = 1'b1;
        data_addr = 24'h000100; data_op = F3_SW; data_wdata = 32'hDEADBEEF; data_store = 1'b1;
        tick();
        instr_pop = 1'b0; data_store = 1'b0;
        check("sw_busy", 32'(data_busy), 32'd1);
        check("sw_not_yet", 32'(mem_write_n), 32'h3);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("sw_held_size", 32'(mem_write_n), 32'(MEM_WORD));
            check("sw_held_data", mem_wdata, 32'hDEADBEEF);
            tick();
        end
        mem_busy = 1'b0;
        check("sw_accept_size", 32'(mem_write_n), 32'(MEM_WORD));
        check("sw_accept_addr", 32'(mem_addr), 32'h100);
        tick();
        $display("store: write_n=%b busy=%b reads=%0d", mem_write_n, data_busy, rd_count);
        check("sw_done_size", 32'(mem_write_n), 32'h3);
        check("sw_busy_fall", 32'(data_busy), 32'd0);
        check("sw_no_fetch", 32'(rd_count), 32'(base));
        tick(4);
        check("sw_then_fetch", 32'(rd_count), 32'(base + 1));
        check("sw_then_addr", 32'(last_rd_addr), 32'h6);

        // Restart to 0x10, then restart to 0x40 while the 0x10 fetch is held
        mem_busy = 1'b1; instr_addr = 23'h8; instr_restart = 1'b1;
        tick();
        instr_restart = 1'b0;
        check("rs_flush", 32'(instr_valid), 32'd0);
        tick();
        check("rs_fetch_addr", 32'(mem_addr), 32'h10);
        check("rs_fetch_size", 32'(mem_read_n), 32'(MEM_HALF));
        instr_addr = 23'h20; instr_restart = 1'b1;
        tick();
        instr_restart = 1'b0; mem_busy = 1'b0;
        check("rs_valid_a", 32'(instr_valid), 32'd0);
        tick(2);
        check("rs_discarded", 32'(instr_valid), 32'd0);
        check("rs_old_returned", 32'(last_rd_addr), 32'h10);
        tick(3);
        $display("restart: last=%h valid=%b head=%h", last_rd_addr, instr_valid, instr_data);
        check("rs_new_addr", 32'(last_rd_addr), 32'h40);
        check("rs_valid", 32'(instr_valid), 32'd1);
        check("rs_head", 32'(instr_data), 32'hC040);
        tick(8);

        // data_load while a fetch is in flight: fetch completes, then the load goes out
        load_addr = 24'h003000; load_word = 32'h87654321;
        data_addr = 24'h003000; data_op = F3_LW;
        base = rd_count;
        instr_pop = 1'b1;
        tick(2);
        instr_pop = 1'b0; data_load = 1'b1;
        check("lf_fetch_size", 32'(mem_read_n), 32'(MEM_HALF));
        check("lf_fetch_addr", 32'(mem_addr), 32'h44);
        tick();
        data_load = 1'b0;
        check("lf_busy", 32'(data_busy), 32'd1);
        tick();
        check("lf_pushed", 32'(instr_valid), 32'd1);
        check("lf_head", 32'(instr_data), 32'hC044);
        check("lf_reads", 32'(rd_count), 32'(base + 1));
        tick();
        $display("load after fetch: read_n=%b addr=%h", mem_read_n, mem_addr);
        check("lf_load_size", 32'(mem_read_n), 32'(MEM_WORD));
        check("lf_load_addr", 32'(mem_addr), 32'h3000);

        // Reset in the middle of the stream window
        wait_ready(40);
        check("rst_stream_seen", 32'(found), 32'd1);
        tick(2);
        rstn = 1'b0;
        tick();
        check("rst_stream_ready", 32'(load_data_ready), 32'd0);
        check("rst_stream_read_n", 32'(mem_read_n), 32'h3);
        check("rst_stream_busy", 32'(data_busy), 32'd0);
        check("rst_stream_valid", 32'(instr_valid), 32'd0);
        check("rst_stream_nibble", 32'(load_nibble), 32'd0);
        base = rd_count;
        tick(2);
        check("rst_hold_no_req", 32'(rd_count), 32'(base));
        rstn = 1'b1;
        tick(3);
        check("rst_refetch_addr", 32'(last_rd_addr), 32'h0);
        check("rst_refetch_count", 32'(rd_count), 32'(base + 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
